// File: rtl/arm7tdmi_pkg.sv
// Shared ARM7TDMI types and constants used by the coprocessor issue sequencer.
// This package holds the coprocessor op type, the issue FSM states, the instruction field positions and the class codes.
package arm7tdmi_pkg;

   typedef enum logic [1:0] {
      CP_CDP = 2'd0,
      CP_MCR = 2'd1,
      CP_MRC = 2'd2
   } cp_op_t;

   typedef enum logic [2:0] {
      CPI_IDLE  = 3'd0,
      CPI_ISSUE = 3'd1,
      CPI_WAIT  = 3'd2,
      CPI_WB    = 3'd3,
      CPI_UNDEF = 3'd4
   } cp_issue_state_t;

   localparam logic [3:0] CP_CLASS_REG = 4'b1110;
   localparam logic [2:0] CP_CLASS_LS  = 3'b110;

   localparam int F_CRM_LSB    = 0;
   localparam int F_CDP_BIT    = 4;
   localparam int F_OP2_LSB    = 5;
   localparam int F_CP_NUM_LSB = 8;
   localparam int F_RD_LSB     = 12;
   localparam int F_CRN_LSB    = 16;
   localparam int F_L_BIT      = 20;
   localparam int F_OP1_LSB    = 21;
   localparam int F_CLASS_LSB  = 24;
   localparam int F_LS_LSB     = 25;

   // Register-transfer class only; bit4 separates CDP, bit20 separates MRC from MCR.
   function automatic cp_op_t cp_decode_op(input logic [31:0] instr);
      cp_op_t op;
      if (!instr[F_CDP_BIT])   op = CP_CDP;
      else if (instr[F_L_BIT]) op = CP_MRC;
      else                     op = CP_MCR;
      return op;
   endfunction

endpackage

// File: rtl/arm7tdmi_cp_issue_if.sv
// Bundle of decode, coprocessor and write-back signals around the coprocessor issue sequencer.
// Handshake: an instruction is taken when instr_valid && instr_ready; instr_ready is high only while idle.
interface arm7tdmi_cp_issue_if;
   import arm7tdmi_pkg::*;

   logic            instr_valid;
   logic [31:0]     instr;
   logic            cond_pass;
   logic [31:0]     rs_data;
   logic            flush;
   logic            instr_ready;

   logic            cp_en;
   cp_op_t          cp_op;
   logic [3:0]      cp_num;
   logic [3:0]      cp_crn;
   logic [3:0]      cp_crm;
   logic [2:0]      cp_op1;
   logic [2:0]      cp_op2;
   logic [31:0]     cp_data_in;
   logic            cp_busy;
   logic            cp_absent;
   logic [31:0]     cp_data_out;

   logic            rd_we;
   logic [3:0]      rd_addr;
   logic [31:0]     rd_wdata;
   logic            flags_we;
   logic [3:0]      flags;
   logic            undef_req;
   logic            done;

   cp_issue_state_t dbg_state;

   modport slave (
      input  instr_valid, instr, cond_pass, rs_data, flush,
      input  cp_busy, cp_absent, cp_data_out,
      output instr_ready, cp_en, cp_op, cp_num, cp_crn, cp_crm, cp_op1, cp_op2, cp_data_in,
      output rd_we, rd_addr, rd_wdata, flags_we, flags, undef_req, done, dbg_state
   );

   modport master (
      output instr_valid, instr, cond_pass, rs_data, flush,
      output cp_busy, cp_absent, cp_data_out,
      input  instr_ready, cp_en, cp_op, cp_num, cp_crn, cp_crm, cp_op1, cp_op2, cp_data_in,
      input  rd_we, rd_addr, rd_wdata, flags_we, flags, undef_req, done, dbg_state
   );

endinterface

// File: rtl/arm7tdmi_cp_issue.sv
// Coprocessor issue sequencer: latches one decoded coprocessor instruction and drives the cp_* bus.
// It also waits out busy, raises undef on absent, LDC/STC or timeout, and writes MRC results back.
module arm7tdmi_cp_issue
   import arm7tdmi_pkg::*;
#(
   parameter int BUSY_TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst_n,
   arm7tdmi_cp_issue_if.slave bus
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = CPI_IDLE;
   localparam logic [2:0] S_ISSUE = CPI_ISSUE;
   localparam logic [2:0] S_WAIT  = CPI_WAIT;
   localparam logic [2:0] S_WB    = CPI_WB;
   localparam logic [2:0] S_UNDEF = CPI_UNDEF;

   logic [2:0]       r_state;
   cp_op_t           r_op;
   logic [3:0]       r_num;
   logic [3:0]       r_crn;
   logic [3:0]       r_crm;
   logic [2:0]       r_op1;
   logic [2:0]       r_op2;
   logic [3:0]       r_rd;
   logic [31:0]      r_data_in;
   logic [31:0]      r_rdata;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   logic [2:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_done_nxt;
   logic             w_capture;
   logic             w_accept;
   logic             w_is_ls;
   logic             w_in_cp;
   logic             w_timeout;
   logic             w_rd_pc;

   assign w_accept  = bus.instr_valid && (r_state == S_IDLE);
   assign w_is_ls   = (bus.instr[F_LS_LSB +: 3] == CP_CLASS_LS);
   assign w_in_cp   = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = (w_cnt_inc == CNT_W'(BUSY_TIMEOUT));
   assign w_rd_pc   = (r_rd == 4'd15);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!bus.cond_pass)  w_done_nxt  = 1'b1;
               else if (w_is_ls)    w_state_nxt = S_UNDEF;
               else                 w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (bus.cp_absent) begin
               w_state_nxt = S_UNDEF;
            end else if (bus.cp_busy) begin
               if (r_state == S_ISSUE) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_timeout) w_state_nxt = S_UNDEF;
               end
            end else if (r_op == CP_MRC) begin
               w_state_nxt = S_WB;
               w_capture   = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         S_WB: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Flush abandons whatever is in flight, including a same-cycle acceptance.
      if (bus.flush) begin
         w_state_nxt = S_IDLE;
         w_done_nxt  = 1'b0;
         w_capture   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_op      <= CP_CDP;
         r_num     <= '0;
         r_crn     <= '0;
         r_crm     <= '0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_rd      <= '0;
         r_data_in <= '0;
         r_rdata   <= '0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_op      <= cp_decode_op(bus.instr);
            r_num     <= bus.instr[F_CP_NUM_LSB +: 4];
            r_crn     <= bus.instr[F_CRN_LSB +: 4];
            r_crm     <= bus.instr[F_CRM_LSB +: 4];
            r_op1     <= bus.instr[F_OP1_LSB +: 3];
            r_op2     <= bus.instr[F_OP2_LSB +: 3];
            r_rd      <= bus.instr[F_RD_LSB +: 4];
            r_data_in <= bus.rs_data;
         end
         if (w_capture) r_rdata <= bus.cp_data_out;
      end
   end

   assign bus.instr_ready = (r_state == S_IDLE);
   assign bus.cp_en       = w_in_cp && !bus.flush;
   assign bus.cp_op       = r_op;
   assign bus.cp_num      = r_num;
   assign bus.cp_crn      = r_crn;
   assign bus.cp_crm      = r_crm;
   assign bus.cp_op1      = r_op1;
   assign bus.cp_op2      = r_op2;
   assign bus.cp_data_in  = r_data_in;
   // Rd=15 on MRC targets the CPSR flags rather than the PC.
   assign bus.rd_we       = (r_state == S_WB) && !w_rd_pc && !bus.flush;
   assign bus.flags_we    = (r_state == S_WB) && w_rd_pc && !bus.flush;
   assign bus.rd_addr     = r_rd;
   assign bus.rd_wdata    = r_rdata;
   assign bus.flags       = r_rdata[31:28];
   assign bus.undef_req   = (r_state == S_UNDEF) && !bus.flush;
   assign bus.done        = r_done;
   assign bus.dbg_state   = cp_issue_state_t'(r_state);

endmodule

// File: doc/arm7tdmi_cp_issue.md
# arm7tdmi_cp_issue

Coprocessor issue sequencer between the decode stage and the coprocessor interface (CP15 and any future coprocessor). It accepts one decoded coprocessor-space instruction at a time and drives the `cp_*` request bus. It waits out `cp_busy`, turns `cp_absent`, unsupported forms and busy timeouts into an undefined-instruction request, and writes MRC results back to the register file or to the CPSR flags.

## Interface
- `BUSY_TIMEOUT`, default 255: maximum number of WAIT cycles before the instruction is treated as undefined; must be ≥1.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `instr_valid`  in  1  decode presents an instruction
- `instr`  in  32  ARM instruction word
- `cond_pass`  in  1  condition code passed; sampled with `instr`
- `rs_data`  in  32  value of ARM register Rd (`instr[15:12]`) for MCR; sampled with `instr`
- `flush`  in  1  pipeline flush; abandons the instruction in flight
- `instr_ready`  out  1  high only in IDLE; acceptance = `instr_valid && instr_ready`
- `cp_en`  out  1  coprocessor request strobe
- `cp_op`  out  `cp_op_t`  CP_CDP / CP_MCR / CP_MRC
- `cp_num`, `cp_crn`, `cp_crm`  out  4 each  fields `[11:8]`, `[19:16]`, `[3:0]`
- `cp_op1`, `cp_op2`  out  3 each  fields `[23:21]`, `[7:5]`
- `cp_data_in`  out  32  latched `rs_data`
- `cp_busy`, `cp_absent`  in  1 each  coprocessor response
- `cp_data_out`  in  32  MRC read data
- `rd_we`  out  1  register-file write strobe
- `rd_addr`  out  4  destination register
- `rd_wdata`  out  32  write data
- `flags_we`  out  1  CPSR NZCV write strobe (MRC with Rd=15)
- `flags`  out  4  NZCV = data[31:28]
- `undef_req`  out  1  one-cycle undefined-instruction exception request
- `done`  out  1  one-cycle retire pulse

## Operation
- Instruction decode:
  - `instr[27:24]`=1110 with bit4=0: CDP.
  - `instr[27:24]`=1110 with bit4=1 and bit20=1: MRC.
  - `instr[27:24]`=1110 with bit4=1 and bit20=0: MCR.
  - `instr[27:25]`=110: LDC/STC. These are not supported and go straight to UNDEF with no `cp_en`.
- On acceptance, the instruction fields, `rs_data` and the op are latched into holding registers. `cp_*` outputs are driven from these registers.
- IDLE → ISSUE: accepted instruction with `cond_pass`=1 and not LDC/STC.
- IDLE → IDLE: accepted instruction with `cond_pass`=0. `done` pulses next cycle; no `cp_en`.
- IDLE → UNDEF: accepted LDC/STC with `cond_pass`=1.
- ISSUE and WAIT:
  - `cp_en`=1 and the fields are held stable.
  - `cp_absent`=1 → UNDEF. Absent has priority over busy.
  - Else `cp_busy`=1 → WAIT, and the WAIT counter is cleared.
  - Else MRC: `cp_data_out` is captured and the FSM goes to WB.
  - Else CDP/MCR → IDLE, with `done` next cycle.
- WAIT counter:
  - Increments each WAIT cycle that `cp_busy`=1.
  - Reaching `BUSY_TIMEOUT` → UNDEF.
  - `cp_busy`=0 in WAIT completes exactly as in ISSUE.
- WB:
  - Rd≠15: `rd_we`=1, `rd_addr`=Rd, `rd_wdata`=captured data.
  - Rd=15: `flags_we`=1, `flags`=data[31:28], `rd_we`=0.
  - Then → IDLE, with `done` next cycle.
- UNDEF: `undef_req`=1 for one cycle → IDLE. No `done` and no write.
- `flush`:
  - Combinationally forces `cp_en`, `rd_we`, `flags_we` and `undef_req` low.
  - The FSM returns to IDLE next cycle and no `done` is issued.
  - A flush coincident with acceptance discards the instruction.

## Timing
- Cycle 0 is the acceptance cycle.
- MCR/CDP with no busy: `cp_en` in cycle 1, `done` in cycle 2.
- MRC: `cp_en` in cycle 1, `rd_we`/`flags_we` in cycle 2, `done` in cycle 3.
- Each busy cycle adds one cycle of `cp_en`.
- Absent: `undef_req` in cycle 2. LDC/STC: `undef_req` in cycle 1.
- `done` is registered. It coincides with `instr_ready`=1, so back-to-back issue is allowed with a 2-cycle MCR throughput.
- Reset:
  - State goes to IDLE and all holding registers and the counter to 0.
  - `cp_en`, `rd_we`, `flags_we`, `undef_req` and `done` are 0.
  - `cp_*` fields and data outputs are 0 and `instr_ready`=1.
- Reset asserted mid-operation abandons the instruction with no outputs on the next edge.

## Structure
- `arm7tdmi_pkg` gets:
  - the `cp_issue_state_t` enum (IDLE, ISSUE, WAIT, WB, UNDEF);
  - the field-position localparams;
  - the opcode-class constants (CP_CLASS_REG=4'b1110, CP_CLASS_LS=3'b110).
- `cp_op_t` is reused from `arm7tdmi_pkg`.
- Single module; decode is inline. No sub-module is warranted.
- Counter width is `$clog2(BUSY_TIMEOUT+1)`.

## Test plan
- **MCR p15,0,R1,c1,c0,0**, `rs_data`=0x00001005: `cp_en` in cycle 1 with `cp_op`=CP_MCR, `cp_crn`=1, `cp_data_in`=0x1005. `done` in cycle 2. No `rd_we`.
- **MRC p15,0,R3,c0,c0,0**, `cp_data_out`=0x41007000: `rd_we` in cycle 2 with `rd_addr`=3 and `rd_wdata`=0x41007000. `done` in cycle 3.
- **MRC with Rd=15**, data 0xA0000000: `flags_we`=1 and `flags`=4'hA, `rd_we`=0.
- **MCR to p14** (`cp_absent`=1): `undef_req` in cycle 2, no `done`. **LDC** instruction: `undef_req` in cycle 1 with no `cp_en`.
- **Busy and timeout:** `cp_busy` held high for 3 cycles gives `cp_en` for 4 cycles, then `done`. With `BUSY_TIMEOUT`=4 and busy stuck high, `undef_req` fires and the FSM returns to IDLE.
- **Flush and condition fail:**
  - `flush` during WAIT of an MRC: no `rd_we`, no `done`, and IDLE next cycle.
  - `cond_pass`=0: no `cp_en`, and `done` in cycle 1.
